// File: rtl/sdp_ram_line_reader.sv
// -----------------------------------------------------------------------------
// sdp_ram_line_reader
//
// Purpose:
//   Read-side controller for one simple_dual_port_ram line buffer on the DVI RX
//   path. A start command reads `length` words beginning at `base_addr`, with
//   the RAM address wrapping modulo 2**ADDR_WIDTH. The words leave as a
//   valid/ready stream, and m_last marks the final word of the command.
//   A 4-entry output FIFO with credit-gated read issue hides the 1- or
//   2-clock RAM read latency, so backpressure never drops or repeats a word.
//
// Parameters:
//   DATA_WIDTH  word width (matches the RAM)
//   ADDR_WIDTH  RAM address width, depth = 2**ADDR_WIDTH
//   OUTPUT_REG  "FALSE" -> RAM read latency 1, "TRUE" -> latency 2
//
// Ports:
//   rclk       single clock (RAM read clock)
//   rst        synchronous active-high reset
//   start      command strobe, sampled only in IDLE
//   base_addr  first RAM address, sampled with start
//   length     word count 0..2**ADDR_WIDTH, sampled with start
//   busy       high from the cycle after start until the final handshake
//   done       one-cycle completion pulse
//   ram_re     RAM read enable
//   ram_raddr  RAM read address
//   ram_rdata  RAM read data
//   m_valid    output stream valid
//   m_ready    output stream ready
//   m_data     output word
//   m_last     high with the final word of a command
//   abort      (only with `define RAM_READER_ABORT_EN) abandons a running
//              command without a done pulse
// -----------------------------------------------------------------------------
module sdp_ram_line_reader #(
  parameter int    DATA_WIDTH = 8,
  parameter int    ADDR_WIDTH = 9,
  parameter string OUTPUT_REG = "FALSE"
) (
  input  logic                  rclk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
`ifdef RAM_READER_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam int LAT = (OUTPUT_REG == "TRUE") ? 2 : 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, ABORT} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH:0]   remaining;    // reads still to issue
  logic [ADDR_WIDTH:0]   beats_left;   // beats still to hand over
  logic [LAT-1:0]        infl_sr;      // one flag per RAM pipeline stage
  logic [DATA_WIDTH-1:0] fifo_mem [4];
  logic [1:0]            wr_ptr, rd_ptr;
  logic [2:0]            fifo_count;
  logic                  zero_done;    // done pulse for a zero-length command
  logic                  cmd_accept;
  logic                  issue, pop, push, abort_req, last_accept;
  logic [2:0]            inflight;
  logic [3:0]            credit_used;

`ifdef RAM_READER_ABORT_EN
  assign abort_req = abort && (state == READ || state == DRAIN);
`else
  assign abort_req = 1'b0;
`endif

  assign cmd_accept = (state == IDLE) && start && (length != '0);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned
    // (which would infer a latch).
    inflight    = 3'($countones(infl_sr));
    m_valid     = (fifo_count != 3'd0);
    pop         = m_valid && m_ready;
    // Occupancy the FIFO will eventually reach: current entries (net of this
    // cycle's pop) plus every read still travelling through the RAM.
    credit_used = {1'b0, fifo_count} + {1'b0, inflight} - 4'(pop);
    issue       = (state == READ) && (remaining != '0) && (credit_used < 4'd4) && !abort_req;
    // Returns landing while aborting are dropped rather than queued.
    push        = infl_sr[LAT-1] && (state != ABORT) && !abort_req;
    m_data      = m_valid ? fifo_mem[rd_ptr] : '0;
    m_last      = m_valid && (beats_left == (ADDR_WIDTH+1)'(1));
    last_accept = (state == DRAIN) && pop && m_last && !abort_req;
    done        = zero_done || last_accept;
    busy        = (state != IDLE);
    ram_re      = issue;

    state_nxt = state;
    unique case (state)
      IDLE:  if (cmd_accept) state_nxt = READ;
      READ:  begin
        if (abort_req) state_nxt = ABORT;
        else if (issue && remaining == (ADDR_WIDTH+1)'(1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (abort_req) state_nxt = ABORT;
        else if (last_accept) state_nxt = IDLE;
      end
      ABORT: if (infl_sr == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rst) begin
      state      <= IDLE;
      remaining  <= '0;
      beats_left <= '0;
      ram_raddr  <= '0;
      infl_sr    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      zero_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      zero_done <= (state == IDLE) && start && (length == '0);
      // The RAM output stage shifts every clock, so the flags shift every clock.
      infl_sr   <= (infl_sr << 1) | LAT'(issue);

      if (cmd_accept) begin
        remaining  <= length;
        beats_left <= length;
        ram_raddr  <= base_addr;
      end else if (abort_req) begin
        remaining  <= '0;
        beats_left <= '0;
      end else begin
        if (issue) begin
          remaining <= remaining - 1'b1;
          ram_raddr <= ram_raddr + 1'b1;  // wraps at the top of the RAM
        end
        if (pop) beats_left <= beats_left - 1'b1;
      end

      if (abort_req) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        fifo_count <= fifo_count + 3'(push) - 3'(pop);
      end
    end
  end

  // NOTE: the FIFO storage is deliberately not reset; m_data is masked to zero
  // whenever the FIFO is empty, so stale entries are never visible.
  always_ff @(posedge rclk) begin
    if (push) fifo_mem[wr_ptr] <= ram_rdata;
  end

endmodule

// File: tb/tb_sdp_ram_line_reader.sv
// -----------------------------------------------------------------------------
// tb_sdp_ram_line_reader
//
// Runs a LAT=1 and a LAT=2 reader side by side on identical commands. Each
// reader has its own behavioural RAM. Every beat is compared against the RAM
// contents at (base + beat index) mod 512. Also checked: address sequence,
// credit bound, hold-under-stall, done/busy timing, reset behaviour and, with
// m_ready held high, the exact beat cycles.
// -----------------------------------------------------------------------------
module tb_sdp_ram_line_reader;

  logic       rclk = 1'b0;
  logic       rst, start, m_ready;
  logic [8:0] base_addr;
  logic [9:0] length;

  logic       busy_w [2], done_w [2], re_w [2], valid_w [2], last_w [2];
  logic [8:0] raddr_w [2];
  logic [7:0] rdata_w [2], data_w [2];

  logic [7:0] ram_mem [512];
  logic [7:0] lat2_stage;

  int vectors     = 0;
  int miscompares = 0;

  always #5 rclk = ~rclk;

  sdp_ram_line_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(9), .OUTPUT_REG("FALSE")) u_dut_lat1 (
    .rclk(rclk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
`ifdef RAM_READER_ABORT_EN
    .abort(1'b0),
`endif
    .busy(busy_w[0]), .done(done_w[0]), .ram_re(re_w[0]), .ram_raddr(raddr_w[0]),
    .ram_rdata(rdata_w[0]), .m_valid(valid_w[0]), .m_ready(m_ready),
    .m_data(data_w[0]), .m_last(last_w[0])
  );

  sdp_ram_line_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(9), .OUTPUT_REG("TRUE")) u_dut_lat2 (
    .rclk(rclk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
`ifdef RAM_READER_ABORT_EN
    .abort(1'b0),
`endif
    .busy(busy_w[1]), .done(done_w[1]), .ram_re(re_w[1]), .ram_raddr(raddr_w[1]),
    .ram_rdata(rdata_w[1]), .m_valid(valid_w[1]), .m_ready(m_ready),
    .m_data(data_w[1]), .m_last(last_w[1])
  );

  // Behavioural RAMs: latency 1, and latency 2 with a free-running output stage.
  always @(posedge rclk) begin
    if (re_w[0]) rdata_w[0] <= ram_mem[raddr_w[0]];
    if (re_w[1]) lat2_stage <= ram_mem[raddr_w[1]];
    rdata_w[1] <= lat2_stage;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_busy"},  32'(busy_w[d]),  0);
      check({tag, "_done"},  32'(done_w[d]),  0);
      check({tag, "_re"},    32'(re_w[d]),    0);
      check({tag, "_raddr"}, 32'(raddr_w[d]), 0);
      check({tag, "_valid"}, 32'(valid_w[d]), 0);
      check({tag, "_last"},  32'(last_w[d]),  0);
      check({tag, "_data"},  32'(data_w[d]),  0);
    end
  endtask

  // Issue one command and follow both readers to completion.
  // rand_ready: toggle m_ready randomly; otherwise hold it high and check
  // exact beat timing. rst_at: cycle at which reset is applied (0 = never).
  task automatic run_cmd(input logic [8:0] b, input int n, input bit rand_ready, input int rst_at);
    int         beat [2];
    int         issued [2];
    bit         fin [2];
    int         fin_cyc [2];
    bit         stall [2];
    logic [7:0] hold_data [2];
    bit         exp_done, pop;
    for (int d = 0; d < 2; d++) begin
      beat[d] = 0; issued[d] = 0; fin[d] = 1'b0; fin_cyc[d] = 0;
      stall[d] = 1'b0; hold_data[d] = '0;
    end
    @(negedge rclk);
    start = 1'b1; base_addr = b; length = 10'(n); m_ready = 1'b1;
    @(negedge rclk);  // now in cycle 1 (edge 0 sampled start)
    start = 1'b0;
    for (int cyc = 1; cyc <= 1200; cyc++) begin
      if (cyc > 1) @(negedge rclk);
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
        pop = valid_w[d] && m_ready;
        if (cyc == 1 && n > 0) check("re_cycle1", 32'(re_w[d]), 1);
        if (re_w[d]) begin
          check("raddr", 32'(raddr_w[d]), 32'((int'(b) + issued[d]) % 512));
          issued[d]++;
          check("issue_count_le_len", 32'(issued[d] <= n), 1);
          check("credit_le_4", 32'((issued[d] - beat[d] - int'(pop)) <= 4), 1);
        end
        if (stall[d]) begin
          check("hold_valid", 32'(valid_w[d]), 1);
          check("hold_data", 32'(data_w[d]), 32'(hold_data[d]));
        end
        if (valid_w[d]) begin
          check("data", 32'(data_w[d]), 32'(ram_mem[(int'(b) + beat[d]) % 512]));
          check("last", 32'(last_w[d]), 32'(beat[d] == n - 1));
          if (!rand_ready) check("beat_cycle", cyc, d + 1 + 2 + beat[d]);
        end
        exp_done = (n == 0) ? (cyc == 1) : (pop && beat[d] == n - 1);
        check("done", 32'(done_w[d]), 32'(exp_done));
        check("busy", 32'(busy_w[d]), 32'(n != 0 && !fin[d]));
        stall[d]     = valid_w[d] && !m_ready;
        hold_data[d] = data_w[d];
        if (pop) beat[d]++;
        if (exp_done) begin
          fin[d]     = 1'b1;
          fin_cyc[d] = cyc;
        end
      end
      if (rst_at == cyc) begin
        rst = 1'b1;
        @(negedge rclk);
        #1;
        check_reset_outputs("midrst");
        rst = 1'b0;
        return;
      end
      if (fin[0] && fin[1] && cyc >= fin_cyc[0] + 3 && cyc >= fin_cyc[1] + 3) break;
    end
    for (int d = 0; d < 2; d++) begin
      check("beat_total", beat[d], n);
      check("issue_total", issued[d], n);
      check("idle_busy", 32'(busy_w[d]), 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ram_mem[i] = 8'(i);
    rst = 1'b1; start = 1'b0; m_ready = 1'b0; base_addr = '0; length = '0;
    repeat (2) @(negedge rclk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    run_cmd(9'h010, 4, 1'b0, 0);   // basic burst, exact timing
    run_cmd(9'h1FE, 4, 1'b0, 0);   // address wrap
    run_cmd(9'h123, 0, 1'b0, 0);   // zero length
    run_cmd(9'h000, 1, 1'b0, 0);   // single word

    for (int i = 0; i < 512; i++) ram_mem[i] = 8'($urandom);
    repeat (4) run_cmd(9'($urandom), 16, 1'b1, 0);    // backpressure
    run_cmd(9'($urandom), 16, 1'b1, 7);               // reset mid-burst
    run_cmd(9'h1F8, 16, 1'b1, 0);                     // clean command after reset
    run_cmd(9'($urandom), 512, 1'b0, 0);              // full depth, every location once
    repeat (3) run_cmd(9'($urandom), int'($urandom_range(1, 40)), 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
